// File: rtl/fb_pkg.sv
// Geometry, bus widths and FSM encoding shared by the framebuffer writer and the
// VGA scan-out.
package fb_pkg;

   localparam int H_RES  = 320;
   localparam int V_RES  = 240;
   localparam int ADDR_W = 17;
   localparam int PIX_W  = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_VB,
      ST_DRAW,
      ST_DONE
   } fb_state_e;

endpackage

// File: rtl/fb_rect_clip.sv
// Clips a rectangle command against the framebuffer edges. Purely combinational.
module fb_rect_clip #(
   parameter int H_RES = fb_pkg::H_RES,
   parameter int V_RES = fb_pkg::V_RES
) (
   input  logic [8:0] x_i,
   input  logic [7:0] y_i,
   input  logic [8:0] w_i,
   input  logic [7:0] h_i,
   output logic [8:0] cw_o,
   output logic [7:0] ch_o,
   output logic       empty_o
);

   logic [9:0] room_x;
   logic [9:0] room_y;
   logic       off_screen;

   // Room to the edge wraps when the origin is off-screen; off_screen covers that case.
   assign room_x     = 10'(H_RES) - {1'b0, x_i};
   assign room_y     = 10'(V_RES) - {2'b00, y_i};
   assign off_screen = ({1'b0, x_i} >= 10'(H_RES)) || ({2'b00, y_i} >= 10'(V_RES));

   assign cw_o    = ({1'b0, w_i} < room_x) ? w_i : room_x[8:0];
   assign ch_o    = ({2'b00, h_i} < room_y) ? h_i : room_y[7:0];
   assign empty_o = off_screen || (cw_o == 9'd0) || (ch_o == 8'd0);

endmodule

// File: rtl/fb_rect_writer.sv
// Filled-rectangle write engine for framebuffer port A: one pixel per clock,
// row-major, optionally held off until the scan-out's vertical-blank pulse.
module fb_rect_writer #(
   parameter int H_RES  = fb_pkg::H_RES,
   parameter int V_RES  = fb_pkg::V_RES,
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int PIX_W  = fb_pkg::PIX_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [8:0]        cmd_x,
   input  logic [7:0]        cmd_y,
   input  logic [8:0]        cmd_w,
   input  logic [7:0]        cmd_h,
   input  logic [PIX_W-1:0]  cmd_color,
   input  logic              cmd_sync,
   input  logic              v_blank_interupt,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_data,
   output logic              fb_we,
   output logic              busy,
   output logic              done
);
   import fb_pkg::*;

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [8:0]        x_q, x_d;
   logic [8:0]        cw_q, cw_d;
   logic [7:0]        ch_q, ch_d;
   logic [8:0]        col_cnt_q, col_cnt_d;
   logic [7:0]        row_cnt_q, row_cnt_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;

   logic [8:0]        clip_cw;
   logic [7:0]        clip_ch;
   logic              clip_empty;
   logic [ADDR_W-1:0] accept_base;

   fb_rect_clip #(.H_RES(H_RES), .V_RES(V_RES)) u_clip (
      .x_i     (cmd_x),
      .y_i     (cmd_y),
      .w_i     (cmd_w),
      .h_i     (cmd_h),
      .cw_o    (clip_cw),
      .ch_o    (clip_ch),
      .empty_o (clip_empty)
   );

   // y*320 as shift-add; only evaluated once per command, never per pixel.
   assign accept_base = (H_RES == 320) ? ((ADDR_W'(cmd_y) << 8) + (ADDR_W'(cmd_y) << 6))
                                       : ADDR_W'(cmd_y) * ADDR_W'(H_RES);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      row_base_d = row_base_q;
      x_d        = x_q;
      cw_d       = cw_q;
      ch_d       = ch_q;
      col_cnt_d  = col_cnt_q;
      row_cnt_d  = row_cnt_q;
      data_d     = data_q;
      we_d       = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               x_d        = cmd_x;
               cw_d       = clip_cw;
               ch_d       = clip_ch;
               data_d     = cmd_color;
               col_cnt_d  = '0;
               row_cnt_d  = '0;
               row_base_d = accept_base;
               addr_d     = accept_base + ADDR_W'(cmd_x);
               if (clip_empty) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (cmd_sync) begin
                  state_d = ST_WAIT_VB;
               end else begin
                  state_d = ST_DRAW;
                  we_d    = 1'b1;
               end
            end
         end
         ST_WAIT_VB: begin
            if (!v_blank_interupt) begin
               state_d = ST_DRAW;
               we_d    = 1'b1;
            end
         end
         ST_DRAW: begin
            if (col_cnt_q + 9'd1 == cw_q) begin
               if (row_cnt_q + 8'd1 == ch_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  col_cnt_d  = '0;
                  row_cnt_d  = row_cnt_q + 8'd1;
                  row_base_d = row_base_q + ADDR_W'(H_RES);
                  addr_d     = row_base_q + ADDR_W'(H_RES) + ADDR_W'(x_q);
                  we_d       = 1'b1;
               end
            end else begin
               col_cnt_d = col_cnt_q + 9'd1;
               addr_d    = addr_q + ADDR_W'(1);
               we_d      = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         row_base_q <= '0;
         x_q        <= '0;
         cw_q       <= '0;
         ch_q       <= '0;
         col_cnt_q  <= '0;
         row_cnt_q  <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         row_base_q <= row_base_d;
         x_q        <= x_d;
         cw_q       <= cw_d;
         ch_q       <= ch_d;
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         data_q     <= data_d;
         we_q       <= we_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign fb_addr   = addr_q;
   assign fb_data   = data_q;
   assign fb_we     = we_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed self-checking bench for fb_rect_writer: draw, clip, empty, vblank sync,
// back-to-back and mid-command reset.
module tb_fb_rect_writer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  cmd_x = '0;
   logic [7:0]  cmd_y = '0;
   logic [8:0]  cmd_w = '0;
   logic [7:0]  cmd_h = '0;
   logic [11:0] cmd_color = '0;
   logic        cmd_sync = 1'b0;
   logic        v_blank_interupt = 1'b1;
   logic [16:0] fb_addr;
   logic [11:0] fb_data;
   logic        fb_we;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   fb_rect_writer dut (
      .clock            (clock),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_x            (cmd_x),
      .cmd_y            (cmd_y),
      .cmd_w            (cmd_w),
      .cmd_h            (cmd_h),
      .cmd_color        (cmd_color),
      .cmd_sync         (cmd_sync),
      .v_blank_interupt (v_blank_interupt),
      .fb_addr          (fb_addr),
      .fb_data          (fb_data),
      .fb_we            (fb_we),
      .busy             (busy),
      .done             (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input int x, input int y, input int w, input int h,
                       input int color, input logic sync);
      cmd_x     = 9'(x);
      cmd_y     = 8'(y);
      cmd_w     = 9'(w);
      cmd_h     = 8'(h);
      cmd_color = 12'(color);
      cmd_sync  = sync;
   endtask

   task automatic send(input int x, input int y, input int w, input int h,
                       input int color, input logic sync);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("send_ready", cmd_ready, 1);
      load(x, y, w, h, color, sync);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Expects cw*ch consecutive writes starting now, then done, then ready.
   task automatic expect_fill(input string tag, input int x0, input int y0,
                              input int cw, input int ch, input int color);
      for (int r = 0; r < ch; r++) begin
         for (int c = 0; c < cw; c++) begin
            check({tag, "_we"}, fb_we, 1);
            check({tag, "_addr"}, fb_addr, (y0 + r) * 320 + x0 + c);
            check({tag, "_data"}, fb_data, color);
            tick();
         end
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_we_off"}, fb_we, 0);
      tick();
      check({tag, "_ready"}, cmd_ready, 1);
      check({tag, "_done_off"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int we_seen;

      // Reset state
      tick();
      tick();
      check("rst_ready", cmd_ready, 0);
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      tick();
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_busy", busy, 0);

      // Basic draw: 650..652, 970..972
      send(10, 2, 3, 2, 'hF00, 1'b0);
      check("basic_first_addr", fb_addr, 650);
      check("basic_busy", busy, 1);
      check("basic_ready_low", cmd_ready, 0);
      expect_fill("basic", 10, 2, 3, 2, 'hF00);

      // Right/bottom clip: 76798, 76799
      send(318, 239, 5, 5, 'h0F0, 1'b0);
      check("clip_first_addr", fb_addr, 76798);
      expect_fill("clip", 318, 239, 2, 1, 'h0F0);

      // Empty commands
      send(5, 5, 0, 3, 'h111, 1'b0);
      check("empty_w_busy", busy, 1);
      expect_fill("empty_w", 5, 5, 0, 0, 'h111);
      send(320, 5, 4, 4, 'h222, 1'b0);
      expect_fill("empty_x", 320, 5, 0, 0, 'h222);
      send(5, 240, 4, 4, 'h333, 1'b0);
      expect_fill("empty_y", 5, 240, 0, 0, 'h333);

      // Sync hold-off; the pulse coincident with acceptance must be ignored
      v_blank_interupt = 1'b0;
      send(0, 0, 2, 1, 'h0AB, 1'b1);
      v_blank_interupt = 1'b1;
      check("sync_wait_busy", busy, 1);
      we_seen = 0;
      for (int i = 0; i < 19; i++) begin
         if (fb_we !== 1'b0) we_seen++;
         tick();
      end
      check("sync_no_early_write", we_seen, 0);
      check("sync_still_busy", busy, 1);
      v_blank_interupt = 1'b0;
      tick();
      v_blank_interupt = 1'b1;
      expect_fill("sync", 0, 0, 2, 1, 'h0AB);

      // Back-to-back with cmd_valid held high
      load(5, 5, 2, 2, 'hABC, 1'b0);
      cmd_valid = 1'b1;
      tick();
      load(100, 100, 3, 1, 'h123, 1'b0);
      expect_fill("b2b_a", 5, 5, 2, 2, 'hABC);
      tick();
      cmd_valid = 1'b0;
      expect_fill("b2b_b", 100, 100, 3, 1, 'h123);

      // Reset during the third write of a 4x4 fill
      send(0, 10, 4, 4, 'h456, 1'b0);
      tick();
      tick();
      check("abort_third_we", fb_we, 1);
      check("abort_third_addr", fb_addr, 3202);
      reset = 1'b1;
      #1;
      check("abort_we", fb_we, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ready", cmd_ready, 0);
      tick();
      tick();
      check("abort_no_done", done, 0);
      reset = 1'b0;
      tick();
      check("abort_ready_back", cmd_ready, 1);
      check("abort_no_done_after", done, 0);
      send(2, 3, 2, 2, 'h0F0, 1'b0);
      expect_fill("after_abort", 2, 3, 2, 2, 'h0F0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
